csa_multi_adder: RTL and testbench
==================================

Name: csa_multi_adder

Overview:
- Parametrised, pipelined multi-operand adder built from registered 3:2 carry-save reduction levels and a final registered carry-propagate adder.
- Successor to the single-level 3-input CSA: adds variable operand count, a signed mode, full-precision result width, valid/ready flow control with backpressure, and reset.
- Sits in the datapath as the summation engine for multiply partial products and multi-term address/accumulate sums.

Parameters:
- WIDTH, 32, bit width of each operand.
- NUM_OPS, 4, operands per beat; legal range 3..9.
- SIGNED, 0, 1 = operands sign-extended to RW; 0 = zero-extended.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- ops  in  NUM_OPS*WIDTH  flattened operands; operand k = ops[k*WIDTH +: WIDTH].
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- result  out  RW  resolved sum, RW = WIDTH + clog2(NUM_OPS).
- cs_s  out  RW  redundant sum vector of the final CSA level, same beat as result.
- cs_c  out  RW  redundant carry vector (already shifted left 1), same beat as result.

Behaviour:
- Reset: asynchronous, active-high on rst. out_valid=0, result=0, cs_s=0, cs_c=0, and all internal stage valids and data = 0. in_ready=1 once rst deasserts.
- Levels: L = 1 for NUM_OPS=3, 2 for 4, 3 for 5..6, 4 for 7..9.
- Structure: each level applies floor(n/3) 3:2 compressors and passes leftover operands through. Every level is registered.
- Latency: LAT = L+1 cycles from accepting a beat to out_valid. The final stage registers result, cs_s and cs_c together.
- Widths: all internal vectors are RW bits. Operands are extended per SIGNED before level 1. Carries are shifted left 1 and truncated to RW. The result is exact (no overflow possible) and is interpreted as two's complement when SIGNED=1.
- Invariant: when out_valid=1, (cs_s + cs_c) mod 2^RW == result.
- Flow control: en = !out_valid | out_ready, and in_ready = en (combinational).
- Pipeline advance: when en=1, every stage (data and valid bit) advances one position, and stage-0 valid loads in_valid. When en=0, all stages hold.
- Stalls: the global stall does not collapse bubbles.
- Handshakes: a beat is accepted iff in_valid & in_ready. A result transfers iff out_valid & out_ready.
- Stall hold: while out_valid=1 and out_ready=0, result, cs_s and cs_c are stable. No beat is lost or duplicated.
- Empty pipeline: out_valid=0; in_ready=1 regardless of out_ready.
- Ordering and throughput: results are in strict acceptance order. Throughput is 1 beat/cycle when out_ready is held high.
- Data checking: output data while out_valid=0 is unspecified and must not be checked.
- Reset mid-operation: all in-flight beats are discarded immediately. No result for them ever appears after rst deasserts.
- in_valid asserted during reset: the beat is ignored.

Test Plan (WIDTH=32, NUM_OPS=4, so RW=34 and LAT=3, unless noted):
- Reset: pulse rst asynchronously mid-cycle -> out_valid=0 and result=0 immediately; in_ready=1 after release.
- Single beat: ops={0x0000F0F0, 0x0F0F0F0F, 0, 0}, in_valid for 1 cycle at edge T, out_ready=1 -> out_valid=1 at edge T+3 only, result=34'h0_0F0F_FFFF, cs_s+cs_c mod 2^34 = same.
- Width extremes, unsigned: four operands of 0xFFFFFFFF -> result=34'h3_FFFF_FFFC.
- Width extremes, signed (SIGNED=1): four of 0x7FFFFFFF -> result=34'h1_FFFF_FFFC; four of 0x80000000 -> result=34'h2_0000_0000.
- Streaming: 10 back-to-back beats with operand k = i+k (i = beat index 0..9) -> 10 consecutive out_valid cycles with result=4i+6, in order.
- Backpressure: stream 8 beats while dropping out_ready for 4 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, all 8 results delivered once and in order.
- Reset mid-operation: accept 2 beats, assert rst 1 cycle later -> no out_valid ever for those beats. A new beat after release gives a correct result at LAT.
- Scaling: NUM_OPS=9, WIDTH=8, nine operands of 0xFF -> LAT=5, RW=12, result=12'h8F7.

Source files
------------

// File: rtl/csa_multi_adder.sv
// csa_multi_adder: pipelined multi-operand adder. Operands are extended to the
// full result width, reduced through registered levels of 3:2 carry-save
// compressors down to a sum/carry pair, then resolved by a registered
// carry-propagate adder. A single global enable gives valid/ready flow control.
module csa_multi_adder #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 4,
    parameter bit SIGNED  = 1'b0,
    localparam int RW     = WIDTH + $clog2(NUM_OPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_OPS*WIDTH-1:0] ops,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RW-1:0]            result,
    output logic [RW-1:0]            cs_s,
    output logic [RW-1:0]            cs_c
);

    // Number of vectors entering reduction level lvl (level 0 sees the operands).
    function automatic int ops_at(input int lvl);
        int n;
        n = NUM_OPS;
        for (int i = 0; i < lvl; i++) n = n - n / 3;
        return n;
    endfunction

    // Levels needed until only a sum/carry pair is left.
    function automatic int count_levels();
        int n;
        int l;
        n = NUM_OPS;
        l = 0;
        while (n > 2) begin
            n = n - n / 3;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int L = count_levels();

    logic          en;
    logic [RW-1:0] ext [NUM_OPS];

    // The whole pipeline moves together; it only freezes when a finished
    // result is waiting on a stalled consumer, so bubbles are never squeezed out.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Extend every operand to RW bits: sign bit replicated in signed mode, zeros otherwise.
    always_comb begin
        for (int k = 0; k < NUM_OPS; k++) begin
            ext[k] = {{(RW - WIDTH){SIGNED & ops[k*WIDTH + WIDTH - 1]}}, ops[k*WIDTH +: WIDTH]};
        end
    end

    for (genvar j = 0; j < L; j++) begin : g_lvl
        localparam int N_IN  = ops_at(j);
        localparam int N_CSA = N_IN / 3;

        logic [RW-1:0] din [NUM_OPS];
        logic [RW-1:0] d   [NUM_OPS];
        logic [RW-1:0] q   [NUM_OPS];
        logic          vin;
        logic          v;

        if (j == 0) begin : g_first
            assign din = ext;
            assign vin = in_valid;
        end else begin : g_next
            assign din = g_lvl[j-1].q;
            assign vin = g_lvl[j-1].v;
        end

        // Compress each group of three into sum + shifted carry; leftovers pass through.
        // Compressor outputs occupy the low slots, so the last level yields s in [0], c in [1].
        always_comb begin
            // NOTE: every slot gets a default before the selective writes, so no latch is inferred.
            for (int k = 0; k < NUM_OPS; k++) d[k] = '0;
            for (int i = 0; i < N_CSA; i++) begin
                d[2*i]   = din[3*i] ^ din[3*i+1] ^ din[3*i+2];
                d[2*i+1] = ((din[3*i] & din[3*i+1]) |
                            (din[3*i] & din[3*i+2]) |
                            (din[3*i+1] & din[3*i+2])) << 1;
            end
            for (int k = 3 * N_CSA; k < N_IN; k++) d[k - N_CSA] = din[k];
        end

        // Level register: data and valid advance together under the global enable.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                // NOTE: data registers are cleared too, so a reset pipeline holds no stale partial sums.
                for (int k = 0; k < NUM_OPS; k++) q[k] <= '0;
            end else if (en) begin
                // NOTE: state uses non-blocking assignment so every level samples the pre-edge value of the one before.
                v <= vin;
                for (int k = 0; k < NUM_OPS; k++) q[k] <= d[k];
            end
        end
    end

    // Final stage: resolve the last sum/carry pair and register it alongside the redundant form.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            cs_s      <= '0;
            cs_c      <= '0;
        end else if (en) begin
            out_valid <= g_lvl[L-1].v;
            cs_s      <= g_lvl[L-1].q[0];
            cs_c      <= g_lvl[L-1].q[1];
            result    <= g_lvl[L-1].q[0] + g_lvl[L-1].q[1];
        end
    end

endmodule

// File: tb/tb_csa_multi_adder.sv
// Testbench for csa_multi_adder: a queue-based reference model for the default
// configuration, plus directed vectors with literal expectations for signed
// mode and a nine-operand instance.
module tb_csa_multi_adder;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int RW  = 34;
    localparam int LAT = 3;

    logic clk;
    logic rst;

    logic            in_valid, in_ready, out_valid, out_ready;
    logic [N*W-1:0]  ops;
    logic [RW-1:0]   result, cs_s, cs_c;

    logic            sg_in_valid, sg_in_ready, sg_out_valid, sg_out_ready;
    logic [127:0]    sg_ops;
    logic [33:0]     sg_result, sg_cs_s, sg_cs_c;

    logic            sc_in_valid, sc_in_ready, sc_out_valid, sc_out_ready;
    logic [71:0]     sc_ops;
    logic [11:0]     sc_result, sc_cs_s, sc_cs_c;

    int nvec = 0;
    int nerr = 0;

    csa_multi_adder #(.WIDTH(32), .NUM_OPS(4), .SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ops(ops),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .cs_s(cs_s), .cs_c(cs_c)
    );

    csa_multi_adder #(.WIDTH(32), .NUM_OPS(4), .SIGNED(1'b1)) dut_signed (
        .clk(clk), .rst(rst), .in_valid(sg_in_valid), .in_ready(sg_in_ready), .ops(sg_ops),
        .out_valid(sg_out_valid), .out_ready(sg_out_ready), .result(sg_result),
        .cs_s(sg_cs_s), .cs_c(sg_cs_c)
    );

    csa_multi_adder #(.WIDTH(8), .NUM_OPS(9), .SIGNED(1'b0)) dut_nine (
        .clk(clk), .rst(rst), .in_valid(sc_in_valid), .in_ready(sc_in_ready), .ops(sc_ops),
        .out_valid(sc_out_valid), .out_ready(sc_out_ready), .result(sc_result),
        .cs_s(sc_cs_s), .cs_c(sc_cs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the exact arithmetic sum of the four unsigned operands.
    function automatic logic [33:0] model_sum(input logic [127:0] v);
        logic [33:0] s;
        s = '0;
        for (int k = 0; k < 4; k++) s = s + 34'(v[k*32 +: 32]);
        return s;
    endfunction

    // Scoreboard for the default instance: accepted beats queue up, results must
    // appear in the same order, be stable while stalled, and never appear unasked.
    logic [33:0] exp_q[$];
    logic        prev_hold;
    logic [33:0] prev_result, prev_s, prev_c;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_hold) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_result", result, prev_result);
                check("hold_cs_s", cs_s, prev_s);
                check("hold_cs_c", cs_c, prev_c);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    check("model_result", result, exp_q[0]);
                    check("model_cs_sum", 34'(cs_s + cs_c), exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            prev_hold   = out_valid && !out_ready;
            prev_result = result;
            prev_s      = cs_s;
            prev_c      = cs_c;
            if (in_valid && in_ready) exp_q.push_back(model_sum(ops));
        end
    end

    function automatic logic pick_ready(input int which);
        case (which)
            0:       return in_ready;
            1:       return sg_in_ready;
            default: return sc_in_ready;
        endcase
    endfunction

    function automatic logic pick_valid(input int which);
        case (which)
            0:       return out_valid;
            1:       return sg_out_valid;
            default: return sc_out_valid;
        endcase
    endfunction

    function automatic logic [63:0] pick_result(input int which);
        case (which)
            0:       return 64'(result);
            1:       return 64'(sg_result);
            default: return 64'(sc_result);
        endcase
    endfunction

    function automatic logic [63:0] pick_cs(input int which);
        case (which)
            0:       return 64'(34'(cs_s + cs_c));
            1:       return 64'(34'(sg_cs_s + sg_cs_c));
            default: return 64'(12'(sc_cs_s + sc_cs_c));
        endcase
    endfunction

    task automatic drive(input int which, input logic [127:0] vec, input logic v);
        case (which)
            0:       begin ops    = vec;        in_valid    = v; end
            1:       begin sg_ops = vec;        sg_in_valid = v; end
            default: begin sc_ops = vec[71:0];  sc_in_valid = v; end
        endcase
    endtask

    // One beat into an idle instance: checks latency, result, redundant sum, single-cycle output.
    task automatic measure(input int which, input logic [127:0] vec, input logic [63:0] exp,
                           input int exp_lat, input string name);
        int n;
        @(posedge clk); #1;
        check({name, "_in_ready"}, pick_ready(which), 1'b1);
        drive(which, vec, 1'b1);
        n = 0;
        do begin
            @(posedge clk); #1;
            if (n == 0) drive(which, vec, 1'b0);
            n++;
        end while (!pick_valid(which) && n < 20);
        check({name, "_latency"}, 64'(n), 64'(exp_lat));
        check({name, "_result"}, pick_result(which), exp);
        check({name, "_cs_sum"}, pick_cs(which), exp);
        @(posedge clk); #1;
        check({name, "_single_cycle"}, pick_valid(which), 1'b0);
    endtask

    logic [33:0] got[$];
    int          first_cyc, last_cyc, bi, n, cnt;
    logic        acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; ops = '0; out_ready = 1'b1;
        sg_in_valid = 1'b0; sg_ops = '0; sg_out_ready = 1'b1;
        sc_in_valid = 1'b0; sc_ops = '0; sc_out_ready = 1'b1;

        // Power-on reset state, released mid-cycle.
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", result, '0);
        check("reset_cs_s", cs_s, '0);
        check("reset_cs_c", cs_c, '0);
        #2 rst = 1'b0;
        #1 check("reset_in_ready", in_ready, 1'b1);

        // Single beats with literal expectations.
        measure(0, {32'h0, 32'h0, 32'h0F0F_0F0F, 32'h0000_F0F0}, 64'h0_0F0F_FFFF, LAT, "single");
        measure(0, {4{32'hFFFF_FFFF}}, 64'h3_FFFF_FFFC, LAT, "umax");
        measure(1, {4{32'h7FFF_FFFF}}, 64'h1_FFFF_FFFC, LAT, "smax");
        measure(1, {4{32'h8000_0000}}, 64'h2_0000_0000, LAT, "smin");
        measure(1, {32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0005}, 64'h3, LAT, "smix");
        measure(2, 128'({9{8'hFF}}), 64'h8F7, 5, "nine_ops");

        // Streaming: ten back-to-back beats, operand k = i + k.
        got.delete(); first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                got.push_back(result);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (cyc < 10) begin
                ops = {32'(cyc + 3), 32'(cyc + 2), 32'(cyc + 1), 32'(cyc)};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream_count", 64'(got.size()), 64'd10);
        check("stream_contiguous", 64'(last_cyc - first_cyc + 1), 64'd10);
        for (int j = 0; j < got.size(); j++) check("stream_value", got[j], 34'(4 * j + 6));

        // Backpressure: eight beats, consumer stalls four cycles mid-stream.
        got.delete(); bi = 0; acc = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
            @(posedge clk); #1;
            if (acc) bi++;
            out_ready = !(cyc >= 6 && cyc < 10);
            if (bi < 8) begin
                ops = {32'(bi * 16 + 3), 32'(bi * 16 + 2), 32'(bi * 16 + 1), 32'(bi * 16)};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(result);
            if (!out_ready) check("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", 64'(got.size()), 64'd8);
        for (int j = 0; j < got.size(); j++) check("bp_value", got[j], 34'(64 * j + 6));

        // Asynchronous reset while a result is held by a stalled consumer.
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0; ops = {4{32'hFFFF_FFFF}}; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("hold_reached", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_result", result, '0);
        check("async_cs_s", cs_s, '0);
        check("async_cs_c", cs_c, '0);

        // A beat presented during reset must be ignored.
        @(posedge clk); #1 ops = {4{32'h1234_5678}}; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        #2 rst = 1'b0; out_ready = 1'b1;

        // Reset mid-operation: two accepted beats are discarded.
        @(posedge clk); #1 ops = {4{32'h0000_0011}}; in_valid = 1'b1;
        @(posedge clk); #1 ops = {4{32'h0000_0022}};
        @(posedge clk); #1 in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check("midop_out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        cnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        check("midop_flushed", 64'(cnt), 64'd0);
        measure(0, {32'd4, 32'd3, 32'd2, 32'd1}, 64'd10, LAT, "after_reset");

        repeat (5) @(posedge clk);
        #1 check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
